// File: rtl/mips64_pkg.sv
// rtl/mips64_pkg.sv - shared fetch FSM encodings and instruction constants
package mips64_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } ifu_state_e;

    localparam logic [5:0]  OPC_J    = 6'b000010;
    localparam logic [31:0] INST_NOP = 32'h0000_0000;
    localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - instruction memory req/ack bus
interface inst_fetch_unit_if #(
    parameter int SIZE   = 32,
    parameter int ADDR_W = 64
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [SIZE-1:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifu_next_pc.sv
// rtl/ifu_next_pc.sv - next-PC selection (+4, branch, J target under IFU_JUMP_EN)
module ifu_next_pc
    import mips64_pkg::*;
#(
    parameter int SIZE   = 32,
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [SIZE-1:0]   inst_i,
    input  logic              branch_i,
    output logic [ADDR_W-1:0] next_pc_o
);
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_pc;

    // All arithmetic wraps naturally at 2^ADDR_W.
    assign seq_pc = pc_i + ADDR_W'(PC_STEP);
    assign br_off = {{(ADDR_W-18){inst_i[15]}}, inst_i[15:0], 2'b00};
    assign br_pc  = seq_pc + br_off;

`ifdef IFU_JUMP_EN
    logic [ADDR_W-1:0] jmp_pc;

    // J keeps the upper bits of the delay-slot address and replaces the rest.
    assign jmp_pc = {seq_pc[ADDR_W-1:28], inst_i[25:0], 2'b00};

    // Jump outranks a taken branch.
    always_comb begin
        next_pc_o = seq_pc;
        if (inst_i[31:26] == OPC_J) begin
            next_pc_o = jmp_pc;
        end else if (branch_i) begin
            next_pc_o = br_pc;
        end
    end
`else
    logic unused_inst_hi;
    assign unused_inst_hi = &{1'b0, inst_i[SIZE-1:16]};

    // Sequential or taken-branch target only.
    always_comb begin
        next_pc_o = seq_pc;
        if (branch_i) begin
            next_pc_o = br_pc;
        end
    end
`endif
endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC owner and instruction fetch FSM (optional J via IFU_JUMP_EN)
module inst_fetch_unit
    import mips64_pkg::*;
#(
    parameter int                SIZE     = 32,
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCen,
    input  logic              PCSrc,
    output logic [SIZE-1:0]   inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       retire_cnt,
    inst_fetch_unit_if.master imem
);
    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SIZE-1:0]   inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       retire_cnt_q, retire_cnt_d;
    logic [ADDR_W-1:0] next_pc;

    ifu_next_pc #(
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc_i      (pc_q),
        .inst_i    (inst_q),
        .branch_i  (PCSrc),
        .next_pc_o (next_pc)
    );

    // State and architectural registers; reset aborts any in-flight fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= SIZE'(INST_NOP);
            inst_valid_q <= 1'b0;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Next-state logic; PCen/PCSrc matter only in S_HOLD, imem_ack only in S_FETCH.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        retire_cnt_d = retire_cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem.imem_ack) begin
                    inst_d       = imem.imem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (PCen) begin
                    pc_d         = next_pc;
                    inst_d       = SIZE'(INST_NOP);
                    inst_valid_d = 1'b0;
                    retire_cnt_d = retire_cnt_q + 32'd1;
                    state_d      = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request is decoded from the state so an async reset drops it at once.
    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;
    assign inst           = inst_q;
    assign inst_valid     = inst_valid_q;
    assign pc             = pc_q;
    assign retire_cnt     = retire_cnt_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - table-driven self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;
    import mips64_pkg::*;

    typedef struct {
        int          ack_delay;
        logic [31:0] rdata;
        logic        pcsrc;
        int          stall;
        logic [63:0] pc;
        logic [63:0] next_pc;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } sb_t;

`ifdef IFU_JUMP_EN
    localparam logic [63:0] J_NEXT = 64'h0000_0000_0000_0100;
`else
    localparam logic [63:0] J_NEXT = 64'h0000_0000_0000_1004;
`endif
    localparam int NV = 8;

    logic        clk;
    logic        rst_n;
    logic        PCen;
    logic        PCSrc;
    logic [31:0] inst;
    logic        inst_valid;
    logic [63:0] pc;
    logic [31:0] retire_cnt;

    int          n_checks;
    int          n_fail;
    int          exp_retire;
    vec_t        vecs [NV];
    sb_t         sb [$];

    inst_fetch_unit_if #(.SIZE(32), .ADDR_W(64)) imem_bus ();

    inst_fetch_unit #(.SIZE(32), .ADDR_W(64), .RESET_PC(64'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCen       (PCen),
        .PCSrc      (PCSrc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .retire_cnt (retire_cnt),
        .imem       (imem_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_bus.imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_arrives", {63'd0, imem_bus.imem_req}, 64'd1);
    endtask

    task automatic ack_and_score(input logic [63:0] addr, input logic [31:0] data);
        sb_t e;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = data;
        sb.push_back('{addr, data});
        step();
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hBAD0_BAD0;
        chk("inst_valid_after_ack", {63'd0, inst_valid}, 64'd1);
        chk("req_low_in_hold", {63'd0, imem_bus.imem_req}, 64'd0);
        chk("scoreboard_nonempty", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("inst", {32'd0, inst}, {32'd0, e.inst});
            chk("pc", pc, e.pc);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_retire = 0;
        rst_n      = 1'b0;
        PCen       = 1'b0;
        PCSrc      = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;

        vecs[0] = '{0, 32'h2002_0005, 1'b0, 0, 64'h0,                   64'h4};
        vecs[1] = '{3, 32'h1000_003E, 1'b1, 0, 64'h4,                   64'h100};
        vecs[2] = '{1, 32'h1000_FFFE, 1'b1, 5, 64'h100,                 64'hFC};
        vecs[3] = '{0, 32'h1000_FFBF, 1'b1, 0, 64'hFC,                  64'hFFFF_FFFF_FFFF_FFFC};
        vecs[4] = '{2, 32'h1040_0007, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        vecs[5] = '{0, 32'h1000_03FF, 1'b1, 0, 64'h0,                   64'h1000};
        vecs[6] = '{1, 32'h0800_0040, 1'b0, 0, 64'h1000,                J_NEXT};
        vecs[7] = '{0, 32'h1000_0001, 1'b0, 0, J_NEXT,                  J_NEXT + 64'd4};

        step();
        step();
        chk("rst_pc", pc, 64'h0);
        chk("rst_inst", {32'd0, inst}, 64'h0);
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_req", {63'd0, imem_bus.imem_req}, 64'd0);
        chk("rst_retire", {32'd0, retire_cnt}, 64'd0);
        rst_n = 1'b1;
        chk("idle_no_req", {63'd0, imem_bus.imem_req}, 64'd0);

        for (int i = 0; i < NV; i++) begin
            wait_req();
            chk("fetch_addr", imem_bus.imem_addr, vecs[i].pc);
            for (int d = 0; d < vecs[i].ack_delay; d++) begin
                step();
                chk("req_held", {63'd0, imem_bus.imem_req}, 64'd1);
                chk("addr_held", imem_bus.imem_addr, vecs[i].pc);
                chk("inst_nop_wait", {32'd0, inst}, 64'h0);
                chk("valid_low_wait", {63'd0, inst_valid}, 64'd0);
            end
            ack_and_score(vecs[i].pc, vecs[i].rdata);
            for (int s = 0; s < vecs[i].stall; s++) begin
                PCSrc = (s % 2 == 0);
                imem_bus.imem_ack   = (s == 1);
                imem_bus.imem_rdata = 32'hDEAD_BEEF;
                step();
                imem_bus.imem_ack = 1'b0;
                chk("stall_pc", pc, vecs[i].pc);
                chk("stall_inst", {32'd0, inst}, {32'd0, vecs[i].rdata});
                chk("stall_valid", {63'd0, inst_valid}, 64'd1);
                chk("stall_retire", {32'd0, retire_cnt}, 64'(exp_retire));
                chk("stall_no_req", {63'd0, imem_bus.imem_req}, 64'd0);
            end
            PCen  = 1'b1;
            PCSrc = vecs[i].pcsrc;
            step();
            PCen  = 1'b0;
            PCSrc = 1'b0;
            exp_retire++;
            chk("retire_valid_low", {63'd0, inst_valid}, 64'd0);
            chk("retire_inst_nop", {32'd0, inst}, 64'h0);
            chk("retire_cnt", {32'd0, retire_cnt}, 64'(exp_retire));
            chk("next_req", {63'd0, imem_bus.imem_req}, 64'd1);
            chk("next_addr", imem_bus.imem_addr, vecs[i].next_pc);
        end

        rst_n = 1'b0;
        #1;
        chk("async_rst_req", {63'd0, imem_bus.imem_req}, 64'd0);
        chk("async_rst_pc", pc, 64'h0);
        chk("async_rst_retire", {32'd0, retire_cnt}, 64'd0);
        step();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h1234_5678;
        step();
        imem_bus.imem_ack = 1'b0;
        chk("stale_ack_inst", {32'd0, inst}, 64'h0);
        chk("stale_ack_valid", {63'd0, inst_valid}, 64'd0);
        rst_n = 1'b1;
        wait_req();
        chk("restart_addr", imem_bus.imem_addr, 64'h0);
        ack_and_score(64'h0, 32'h2002_0005);
        chk("restart_retire", {32'd0, retire_cnt}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
